// File: rtl/ram_fetch_pkg.sv
// Shared defaults and width helpers for the pixel fetch buffer.
// Both helpers are constant functions, so they can size ports and parameters.
package ram_fetch_pkg;

  localparam int DEFAULT_XLEN_PIXEL    = 8;
  localparam int DEFAULT_NUM_OF_PIXELS = 900;

  // Address width that covers every stored pixel (indices 0..depth-1).
  function automatic int calc_addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Counter width that can also represent "depth" itself, i.e. a full buffer.
  function automatic int calc_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : ram_fetch_pkg

// File: rtl/ram_fetch_pixel_ram.sv
// Simple dual-port pixel store: synchronous write, registered read, no reset.
// A same-edge read of the address being written returns the previous word.
module pixel_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 900,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Separate read process keeps the read-before-write behaviour explicit.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule : pixel_ram

// File: rtl/ram_fetch.sv
// Pixel load/replay buffer: pixels are loaded sequentially, then replayed in
// order forever while re is held, wrapping at the last loaded pixel.
module ram_fetch
  import ram_fetch_pkg::*;
#(
  parameter int XLEN_PIXEL    = DEFAULT_XLEN_PIXEL,
  parameter int NUM_OF_PIXELS = DEFAULT_NUM_OF_PIXELS,
  localparam int ADDR_W = calc_addr_w(NUM_OF_PIXELS),
  localparam int CNT_W  = calc_cnt_w(NUM_OF_PIXELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [XLEN_PIXEL-1:0] data_load,
  output logic [XLEN_PIXEL-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      wr_count
);

  logic [CNT_W-1:0]      wr_count_q, wr_count_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                  data_valid_q, data_valid_d;
  logic                  out_ok_q, out_ok_d;

  logic                  wr_accept;
  logic                  rd_accept;
  logic                  rd_last;
  logic [ADDR_W-1:0]     waddr;
  logic [XLEN_PIXEL-1:0] ram_rdata;

  // Flags decode the pre-edge count, so a same-edge write never unblocks a read.
  assign full      = (wr_count_q == CNT_W'(NUM_OF_PIXELS));
  assign empty     = (wr_count_q == '0);
  assign wr_accept = we && !full;
  assign rd_accept = re && !empty;
  assign rd_last   = (CNT_W'(rd_ptr_q) == (wr_count_q - CNT_W'(1)));
  assign waddr     = ADDR_W'(wr_count_q);

  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_accept) begin
      wr_count_d = wr_count_q + CNT_W'(1);
    end
  end

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    data_valid_d = 1'b0;
    out_ok_d     = out_ok_q;
    if (rd_accept) begin
      rd_ptr_d     = rd_last ? '0 : rd_ptr_q + ADDR_W'(1);
      data_valid_d = 1'b1;
      out_ok_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count_q   <= '0;
      rd_ptr_q     <= '0;
      data_valid_q <= 1'b0;
      out_ok_q     <= 1'b0;
    end else begin
      wr_count_q   <= wr_count_d;
      rd_ptr_q     <= rd_ptr_d;
      data_valid_q <= data_valid_d;
      out_ok_q     <= out_ok_d;
    end
  end

  pixel_ram #(
    .DATA_W (XLEN_PIXEL),
    .DEPTH  (NUM_OF_PIXELS),
    .ADDR_W (ADDR_W)
  ) u_pixel_ram (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (waddr),
    .wdata (data_load),
    .re    (rd_accept),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // The RAM output register has no reset, so it is masked until the first
  // read after reset has refreshed it; this gives an immediate zero on reset.
  assign data_out   = out_ok_q ? ram_rdata : '0;
  assign data_valid = data_valid_q;
  assign wr_count   = wr_count_q;

endmodule : ram_fetch

// File: tb/tb_ram_fetch.sv
// Self-checking bench for ram_fetch: directed scenarios plus a random
// load/replay stream compared against a queue-based image model.
module tb_ram_fetch;

  localparam int XLEN  = 8;
  localparam int N     = 900;
  localparam int CNT_W = $clog2(N + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             we = 1'b0;
  logic             re = 1'b0;
  logic [XLEN-1:0]  data_load = '0;
  logic [XLEN-1:0]  data_out;
  logic             data_valid;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] wr_count;

  int checks = 0;
  int errors = 0;

  // Reference model: the loaded image as a queue plus a replay position.
  logic [XLEN-1:0] img [$];
  int              rd_m = 0;
  logic [XLEN-1:0] dout_m = '0;
  logic            dv_m = 1'b0;

  ram_fetch #(.XLEN_PIXEL(XLEN), .NUM_OF_PIXELS(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .re         (re),
    .data_load  (data_load),
    .data_out   (data_out),
    .data_valid (data_valid),
    .full       (full),
    .empty      (empty),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, got t=%0t, required < 5000000", $time);
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    img.delete();
    rd_m   = 0;
    dout_m = '0;
    dv_m   = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; we = 1'b0; re = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
  endtask

  // One clock: drive inputs, step the model with the pre-edge image, then
  // leave time at edge+1 for the caller to sample.
  task automatic drive_cycle(input logic w, input logic r, input logic [XLEN-1:0] d);
    int len;
    we = w; re = r; data_load = d;
    @(posedge clk);
    len = img.size();
    if (r && len != 0) begin
      dout_m = img[rd_m];
      dv_m   = 1'b1;
      rd_m   = (rd_m + 1 == len) ? 0 : rd_m + 1;
    end else begin
      dv_m = 1'b0;
    end
    if (w && len < N) img.push_back(d);
    #1;
    $display("t=%0t we=%0b re=%0b din=%02h -> dout=%02h dv=%0b cnt=%0d full=%0b empty=%0b",
             $time, w, r, d, data_out, data_valid, wr_count, full, empty);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (data_out !== '0 || data_valid !== 1'b0 || wr_count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got dout=%h dv=%b cnt=%0d empty=%b full=%b, required 0 0 0 1 0",
               data_out, data_valid, wr_count, empty, full);
    end
  endtask

  task automatic test_empty_read();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 1'b1, XLEN'($urandom));
      checks++;
      if (data_out !== '0 || data_valid !== 1'b0 || empty !== 1'b1) begin
        errors++;
        $display("FAIL empty_read[%0d]: got dout=%h dv=%b empty=%b, required 0 0 1",
                 i, data_out, data_valid, empty);
      end
    end
  endtask

  task automatic test_load_replay();
    apply_reset();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, XLEN'(i));
    checks++;
    if (wr_count !== CNT_W'(5) || empty !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL load5: got cnt=%0d empty=%b full=%b, required 5 0 0", wr_count, empty, full);
    end
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b0, 1'b1, '0);
      checks++;
      if (data_out !== XLEN'(i % 5) || data_valid !== 1'b1) begin
        errors++;
        $display("FAIL replay[%0d]: got dout=%0d dv=%b, required %0d 1", i, data_out, data_valid, i % 5);
      end
    end
    drive_cycle(1'b0, 1'b0, '0);
    checks++;
    if (data_valid !== 1'b0 || data_out !== XLEN'(11 % 5)) begin
      errors++;
      $display("FAIL replay_hold: got dout=%0d dv=%b, required %0d 0", data_out, data_valid, 11 % 5);
    end
  endtask

  task automatic test_full_overflow();
    apply_reset();
    for (int i = 0; i < N; i++) drive_cycle(1'b1, 1'b0, XLEN'(i % 256));
    drive_cycle(1'b1, 1'b0, 8'hAA);
    checks++;
    if (full !== 1'b1 || wr_count !== CNT_W'(N) || empty !== 1'b0) begin
      errors++;
      $display("FAIL full_flag: got full=%b cnt=%0d empty=%b, required 1 %0d 0", full, wr_count, empty, N);
    end
    for (int i = 0; i <= N; i++) begin
      drive_cycle(1'b0, 1'b1, '0);
      checks++;
      if (data_out !== XLEN'(i % N % 256) || data_valid !== 1'b1) begin
        errors++;
        $display("FAIL full_read[%0d]: got dout=%0d dv=%b, required %0d 1", i, data_out, data_valid, i % N % 256);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, XLEN'(20 + i));
    drive_cycle(1'b0, 1'b1, '0);
    drive_cycle(1'b0, 1'b1, '0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (data_out !== '0 || data_valid !== 1'b0 || wr_count !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got dout=%h dv=%b cnt=%0d empty=%b, required 0 0 0 1",
               data_out, data_valid, wr_count, empty);
    end
    we = 1'b0; re = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    drive_cycle(1'b1, 1'b0, 8'd7);
    drive_cycle(1'b0, 1'b1, '0);
    checks++;
    if (data_out !== 8'd7 || data_valid !== 1'b1 || wr_count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL reload_after_reset: got dout=%0d dv=%b cnt=%0d, required 7 1 1", data_out, data_valid, wr_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] exp_seq [4];
    exp_seq = '{8'd10, 8'd11, 8'd12, 8'd13};
    apply_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, XLEN'(10 + i));
    drive_cycle(1'b0, 1'b1, '0);
    drive_cycle(1'b0, 1'b1, '0);
    drive_cycle(1'b1, 1'b1, 8'd13);
    checks++;
    if (data_out !== 8'd12 || data_valid !== 1'b1 || wr_count !== CNT_W'(4)) begin
      errors++;
      $display("FAIL simultaneous_rw: got dout=%0d dv=%b cnt=%0d, required 12 1 4", data_out, data_valid, wr_count);
    end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b1, '0);
      checks++;
      if (data_out !== exp_seq[i] || data_valid !== 1'b1) begin
        errors++;
        $display("FAIL post_wrap[%0d]: got dout=%0d dv=%b, required %0d 1", i, data_out, data_valid, exp_seq[i]);
      end
    end
  endtask

  task automatic test_random();
    logic w, r;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < (i < 200 ? 60 : 25));
      r = ($urandom_range(0, 99) < 55);
      drive_cycle(w, r, XLEN'($urandom));
      checks++;
      if (data_out !== dout_m || data_valid !== dv_m || wr_count !== CNT_W'(img.size()) ||
          empty !== (img.size() == 0) || full !== (img.size() == N)) begin
        errors++;
        $display("FAIL random[%0d]: got dout=%h dv=%b cnt=%0d empty=%b full=%b, required %h %b %0d %b %b",
                 i, data_out, data_valid, wr_count, empty, full,
                 dout_m, dv_m, img.size(), img.size() == 0, img.size() == N);
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty_read();
    test_load_replay();
    test_full_overflow();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ram_fetch
